// File: rtl/spifs_pkg.sv
// Shared definitions for the SPI shift register: default data width,
// length-field width and the transfer state encoding.
package spifs_pkg;

    // Default maximum character length / shift register width.
    localparam int unsigned SPIFS_DATA_W = 32;

    // Width of the character-length field; a value of 0 selects a full DATA_W-bit character.
    localparam int unsigned SPIFS_LEN_W = 5;

    typedef enum logic {
        StIdle,
        StXfer
    } spifs_state_e;

endpackage

// File: rtl/spifs_shift.sv
// SPI shift register: parallel load, serial shift out on the tx strobe and
// serial capture on the rx strobe.
// Optional build macro SPIFS_LSB_EN: when defined, lsb_i selects LSB-first
// ordering; otherwise ordering is MSB-first only and lsb_i is ignored.
module spifs_shift
    import spifs_pkg::*;
#(
    parameter int unsigned DATA_W = SPIFS_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   go_i,
    input  logic [SPIFS_LEN_W-1:0] len_i,
    input  logic                   lsb_i,
    input  logic                   tx_negedge_i,
    input  logic                   rx_negedge_i,
    input  logic                   pos_edge_i,
    input  logic                   neg_edge_i,
    input  logic                   wr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic                   miso_i,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   tip_o,
    output logic                   last_o,
    output logic                   mosi_o,
    output logic                   done_o
);

    // Counter must hold DATA_W itself, so it needs one more bit than a bit index.
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    spifs_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_q;
    logic [IDX_W-1:0]  pos_q;
    logic [DATA_W-1:0] data_q;
    logic              mosi_q;
    logic              tip_q;
    logic              done_q;

    logic              tx_stb;
    logic              rx_stb;
    logic [CNT_W-1:0]  cnt_init;
    logic [IDX_W-1:0]  tx_idx;
    logic              bit_sent;

`ifndef SPIFS_LSB_EN
    logic unused_lsb;
    assign unused_lsb = lsb_i;
`endif

    // Strobe selection, counter load value and index of the next bit to drive.
    always_comb begin
        tx_stb   = tx_negedge_i ? neg_edge_i : pos_edge_i;
        rx_stb   = rx_negedge_i ? neg_edge_i : pos_edge_i;
        cnt_init = (len_i == '0) ? CNT_W'(DATA_W) : CNT_W'(len_i);
        tx_idx   = IDX_W'(cnt_q - CNT_W'(1));
`ifdef SPIFS_LSB_EN
        if (lsb_i) begin
            tx_idx = IDX_W'(len_q - cnt_q);
        end
`endif
        // An rx strobe before the first tx strobe has nothing to capture yet.
        bit_sent = (cnt_q != len_q);
    end

    // Transfer FSM with registered data, counter and outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            pos_q   <= '0;
            data_q  <= '0;
            mosi_q  <= 1'b0;
            tip_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Load wins over start, so the transfer shifts the new data.
                    if (wr_i) begin
                        data_q <= wdata_i;
                    end
                    if (go_i) begin
                        state_q <= StXfer;
                        tip_q   <= 1'b1;
                        cnt_q   <= cnt_init;
                        len_q   <= cnt_init;
                    end
                end
                StXfer: begin
                    // Capture lands in the position last driven; the shift below reads a
                    // different position, so a coincident tx strobe loses nothing.
                    if (rx_stb && bit_sent) begin
                        data_q[pos_q] <= miso_i;
                    end
                    if (rx_stb && (cnt_q == '0)) begin
                        state_q <= StIdle;
                        tip_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    if (tx_stb && (cnt_q != '0)) begin
                        mosi_q <= data_q[tx_idx];
                        pos_q  <= tx_idx;
                        cnt_q  <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign rdata_o = data_q;
    assign tip_o   = tip_q;
    assign mosi_o  = mosi_q;
    assign done_o  = done_q;
    assign last_o  = tip_q && (cnt_q == '0);

endmodule
